ibox_issue: RTL and testbench

Issue and writeback sequencer that drives the combinational Ibox integer datapath. It accepts raw 32-bit Alpha instruction words over a valid/ready handshake and decodes operate and LDA/LDAH formats. It reads operands from an internal 31×64 integer register file, presents `{opcode,func}`/a/b to the Ibox, and commits `ibox_result` back to the register file. Multiply instructions hold the execute stage for a fixed number of cycles, and conditional moves are resolved from the Ibox comparator bit.

---
 rtl/ibox_pkg.sv | 48 ++++
 rtl/ibox_regfile.sv | 24 ++
 rtl/ibox_issue.sv | 121 ++++++++++++
 tb/tb_ibox_issue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ibox_pkg.sv
// ibox_pkg: opcode, field and func-code definitions shared by the Ibox issue sequencer
package ibox_pkg;
  localparam logic [5:0] OP_LDA  = 6'h08;
  localparam logic [5:0] OP_LDAH = 6'h09;
  localparam logic [5:0] OP_INTA = 6'h10;
  localparam logic [5:0] OP_INTL = 6'h11;
  localparam logic [5:0] OP_INTS = 6'h12;
  localparam logic [5:0] OP_INTM = 6'h13;
  localparam int OPC_LSB  = 26;
  localparam int RA_LSB   = 21;
  localparam int RB_LSB   = 16;
  localparam int LIT_LSB  = 13;
  localparam int LIT_BIT  = 12;
  localparam int FUNC_LSB = 5;
  localparam int N_INTA = 22;
  localparam int N_INTL = 14;
  localparam int N_INTS = 26;
  localparam int N_INTM = 5;
  localparam int N_CMOV = 8;
  localparam logic [6:0] INTA_FUNCS [N_INTA] = '{7'h00, 7'h02, 7'h09, 7'h0B, 7'h0F, 7'h12,
    7'h1B, 7'h1D, 7'h20, 7'h22, 7'h29, 7'h2B, 7'h2D, 7'h32, 7'h3B, 7'h3D, 7'h40, 7'h49,
    7'h4D, 7'h60, 7'h69, 7'h6D};
  // AMASK (0x61) and IMPLVER (0x6C) are deliberately absent
  localparam logic [6:0] INTL_FUNCS [N_INTL] = '{7'h00, 7'h08, 7'h14, 7'h16, 7'h20, 7'h24,
    7'h26, 7'h28, 7'h40, 7'h44, 7'h46, 7'h48, 7'h64, 7'h66};
  localparam logic [6:0] INTS_FUNCS [N_INTS] = '{7'h02, 7'h06, 7'h0B, 7'h12, 7'h16, 7'h1B,
    7'h22, 7'h26, 7'h2B, 7'h30, 7'h31, 7'h32, 7'h34, 7'h36, 7'h39, 7'h3B, 7'h3C, 7'h52,
    7'h57, 7'h5A, 7'h62, 7'h67, 7'h6A, 7'h72, 7'h77, 7'h7A};
  localparam logic [6:0] INTM_FUNCS [N_INTM] = '{7'h00, 7'h20, 7'h30, 7'h40, 7'h60};
  localparam logic [6:0] CMOV_FUNCS [N_CMOV] = '{7'h14, 7'h16, 7'h24, 7'h26, 7'h44, 7'h46,
    7'h64, 7'h66};
  typedef enum logic [1:0] {E_IDLE, E_EXEC, E_MUL} e_state_t;
  function automatic logic is_legal(input logic [5:0] opc, input logic [6:0] func);
    logic hit;
    hit = opc == OP_LDA || opc == OP_LDAH;
    for (int i = 0; i < N_INTA; i++) hit |= opc == OP_INTA && func == INTA_FUNCS[i];
    for (int i = 0; i < N_INTL; i++) hit |= opc == OP_INTL && func == INTL_FUNCS[i];
    for (int i = 0; i < N_INTS; i++) hit |= opc == OP_INTS && func == INTS_FUNCS[i];
    for (int i = 0; i < N_INTM; i++) hit |= opc == OP_INTM && func == INTM_FUNCS[i];
    return hit;
  endfunction
  function automatic logic is_cmov(input logic [5:0] opc, input logic [6:0] func);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_CMOV; i++) hit |= opc == OP_INTL && func == CMOV_FUNCS[i];
    return hit;
  endfunction
endpackage

// File: rtl/ibox_regfile.sv
// ibox_regfile: 31x64 integer register file, two async read ports, one sync write port, R31 reads 0
module ibox_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  output logic [63:0] ra_data,
  input  logic [4:0]  rb_addr,
  output logic [63:0] rb_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd
);
  logic [63:0] mem_q [31];
  logic [63:0] mem_d [31];
  always_comb begin
    mem_d = mem_q;
    if (we && wa != 5'd31) mem_d[wa] = wd;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 31; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  assign ra_data = ra_addr == 5'd31 ? '0 : mem_q[ra_addr];
  assign rb_data = rb_addr == 5'd31 ? '0 : mem_q[rb_addr];
endmodule

// File: rtl/ibox_issue.sv
// ibox_issue: decodes Alpha operate/LDA words, feeds the Ibox from registered E-stage operands
// and writes its result back, with a multi-cycle hold for multiplies and a result bypass.
module ibox_issue
  import ibox_pkg::*;
#(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic [12:0] ibox_opcode,
  output logic [63:0] ibox_a,
  output logic [63:0] ibox_b,
  input  logic [63:0] ibox_result,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [63:0] wb_data,
  output logic        illegal
);
  localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
  e_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [12:0] op_q, op_d;
  logic [63:0] a_q, a_d, b_q, b_d;
  logic [4:0] dst_q, dst_d;
  logic cmov_q, cmov_d, ill_q, ill_d;
  logic wb_valid_q, wb_valid_d, illegal_q, illegal_d;
  logic [4:0] wb_reg_q, wb_reg_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic [5:0] opc;
  logic [6:0] func;
  logic [4:0] ra, rb;
  logic is_mem, legal, accept, e_done, commit;
  logic [63:0] commit_val, rf_a, rf_b, rd_a, rd_b;
  assign opc = inst[OPC_LSB +: 6];
  assign func = inst[FUNC_LSB +: 7];
  assign ra = inst[RA_LSB +: 5];
  assign rb = inst[RB_LSB +: 5];
  assign is_mem = opc == OP_LDA || opc == OP_LDAH;
  assign legal = is_legal(opc, func);
  assign inst_ready = !rst && (state_q != E_MUL || cnt_q == MUL_LAT);
  assign accept = inst_valid && inst_ready;
  assign e_done = state_q == E_EXEC || (state_q == E_MUL && cnt_q == MUL_LAT);
  assign commit_val = cmov_q ? b_q : ibox_result;
  assign commit = e_done && !ill_q && dst_q != 5'd31 && (!cmov_q || ibox_result[0]);
  // the value retiring this edge overrides the stale RF entry for a dependent accept
  assign rd_a = commit && dst_q == ra ? commit_val : rf_a;
  assign rd_b = commit && dst_q == rb ? commit_val : rf_b;
  ibox_regfile u_rf (
    .clk    (clk),
    .rst    (rst),
    .ra_addr(ra),
    .ra_data(rf_a),
    .rb_addr(rb),
    .rb_data(rf_b),
    .we     (commit),
    .wa     (dst_q),
    .wd     (commit_val)
  );
  always_comb begin
    state_d = e_done ? E_IDLE : state_q;
    cnt_d = state_q == E_MUL && !e_done ? cnt_q + 4'd1 : cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    dst_d = dst_q;
    cmov_d = cmov_q;
    ill_d = ill_q;
    if (accept) begin
      state_d = opc == OP_INTM && legal ? E_MUL : E_EXEC;
      cnt_d = 4'd1;
      op_d = {opc, is_mem ? 7'd0 : func};
      a_d = is_mem ? {{48{inst[15]}}, inst[15:0]} : rd_a;
      b_d = !is_mem && inst[LIT_BIT] ? {56'd0, inst[LIT_LSB +: 8]} : rd_b;
      dst_d = is_mem ? ra : inst[4:0];
      cmov_d = is_cmov(opc, func);
      ill_d = !legal;
    end
    wb_valid_d = commit;
    wb_reg_d = commit ? dst_q : wb_reg_q;
    wb_data_d = commit ? commit_val : wb_data_q;
    illegal_d = e_done && ill_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= E_IDLE;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      dst_q <= '0;
      cmov_q <= 1'b0;
      ill_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      dst_q <= dst_d;
      cmov_q <= cmov_d;
      ill_q <= ill_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q <= wb_reg_d;
      wb_data_q <= wb_data_d;
      illegal_q <= illegal_d;
    end
  assign ibox_opcode = op_q;
  assign ibox_a = a_q;
  assign ibox_b = b_q;
  assign wb_valid = wb_valid_q;
  assign wb_reg = wb_reg_q;
  assign wb_data = wb_data_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_ibox_issue.sv
// tb_ibox_issue: directed + random checks of ibox_issue against a sequential architectural model
module tb_ibox_issue;
  localparam int L = 4;
  localparam logic [12:0] GOOD [16] = '{{6'h10, 7'h20}, {6'h10, 7'h29}, {6'h10, 7'h00},
    {6'h10, 7'h2D}, {6'h11, 7'h00}, {6'h11, 7'h20}, {6'h11, 7'h40}, {6'h11, 7'h24},
    {6'h11, 7'h26}, {6'h11, 7'h44}, {6'h11, 7'h46}, {6'h11, 7'h14}, {6'h11, 7'h66},
    {6'h12, 7'h39}, {6'h12, 7'h34}, {6'h13, 7'h20}};
  localparam logic [12:0] BAD [7] = '{{6'h11, 7'h61}, {6'h11, 7'h6C}, {6'h10, 7'h01},
    {6'h13, 7'h01}, {6'h12, 7'h00}, {6'h29, 7'h00}, {6'h2D, 7'h00}};
  logic clk = 0, rst = 1, inst_valid = 0;
  logic [31:0] inst = '0;
  logic inst_ready, wb_valid, illegal;
  logic [12:0] ibox_opcode;
  logic [63:0] ibox_a, ibox_b, ibox_result, wb_data;
  logic [4:0] wb_reg;
  int tests = 0, fails = 0, cyc = 0, nrdy = 0;
  logic [63:0] rf_m [32];
  bit ev_wb [int];
  bit ev_ill [int];
  logic [4:0] ev_reg [int];
  logic [63:0] ev_data [int];
  logic [12:0] ev_op [int];
  logic [63:0] ev_a [int];
  logic [63:0] ev_b [int];

  always #5 clk = ~clk;

  ibox_issue #(.MUL_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .ibox_opcode(ibox_opcode), .ibox_a(ibox_a), .ibox_b(ibox_b), .ibox_result(ibox_result),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .illegal(illegal)
  );

  // stand-in for the combinational Ibox datapath
  function automatic logic [63:0] ibox(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [6:0] f;
    f = op[6:0];
    case (op[12:7])
      6'h08: return a + b;
      6'h09: return (a << 16) + b;
      6'h11: case (f)
        7'h00: return a & b;
        7'h20: return a | b;
        7'h40: return a ^ b;
        7'h14: return {63'd0, a[0]};
        7'h16: return {63'd0, !a[0]};
        7'h24: return {63'd0, a == 64'd0};
        7'h26: return {63'd0, a != 64'd0};
        7'h44: return {63'd0, a[63]};
        7'h46: return {63'd0, !a[63]};
        7'h64: return {63'd0, a[63] || a == 64'd0};
        7'h66: return {63'd0, !a[63] && a != 64'd0};
        default: return ~a;
      endcase
      6'h12: return f == 7'h39 ? a << b[5:0] : a >> b[5:0];
      6'h13: return a * b;
      default: return f == 7'h29 ? a - b : f == 7'h2D ? {63'd0, a == b} : a + b;
    endcase
  endfunction

  always_comb ibox_result = ibox(ibox_opcode, ibox_a, ibox_b);

  function automatic logic [31:0] mem(input logic [5:0] o, input logic [4:0] ra, input logic [4:0] rb, input logic [15:0] d);
    return {o, ra, rb, d};
  endfunction
  function automatic logic [31:0] opr(input logic [12:0] of, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc);
    return {of[12:7], ra, rb, 4'b0000, of[6:0], rc};
  endfunction
  function automatic logic [31:0] opl(input logic [12:0] of, input logic [4:0] ra, input logic [7:0] lit, input logic [4:0] rc);
    return {of[12:7], ra, lit, 1'b1, of[6:0], rc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // sequential semantics: each accepted instruction sees all earlier results immediately
  task automatic model_issue(input logic [31:0] w, input bit legal);
    logic [5:0] o;
    logic [63:0] a, b, res;
    logic [12:0] op13;
    logic [4:0] dst;
    bit m, mul, cm;
    int lat;
    o = w[31:26];
    m = o == 6'h08 || o == 6'h09;
    a = m ? {{48{w[15]}}, w[15:0]} : rf_m[w[25:21]];
    b = !m && w[12] ? {56'd0, w[20:13]} : rf_m[w[20:16]];
    op13 = {o, m ? 7'd0 : w[11:5]};
    dst = m ? w[25:21] : w[4:0];
    cm = o == 6'h11 && (w[11:5] inside {7'h14, 7'h16, 7'h24, 7'h26, 7'h44, 7'h46, 7'h64, 7'h66});
    mul = legal && o == 6'h13;
    lat = mul ? L : 1;
    res = ibox(op13, a, b);
    if (legal)
      for (int k = 1; k <= lat; k++) begin
        ev_op[cyc + k] = op13;
        ev_a[cyc + k] = a;
        ev_b[cyc + k] = b;
      end
    if (!legal) ev_ill[cyc + lat + 1] = 1;
    else if (dst != 5'd31 && (!cm || res[0])) begin
      ev_wb[cyc + lat + 1] = 1;
      ev_reg[cyc + lat + 1] = dst;
      ev_data[cyc + lat + 1] = cm ? b : res;
      rf_m[dst] = cm ? b : res;
    end
    nrdy = mul ? cyc + L : cyc + 1;
  endtask

  task automatic step(input bit v, input logic [31:0] w, input bit legal, output bit acc);
    inst_valid = v;
    inst = w;
    @(negedge clk);
    chk("inst_ready", {63'd0, inst_ready}, {63'd0, cyc >= nrdy});
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, ev_wb.exists(cyc) != 0});
    if (ev_wb.exists(cyc)) begin
      chk("wb_reg", {59'd0, wb_reg}, {59'd0, ev_reg[cyc]});
      chk("wb_data", wb_data, ev_data[cyc]);
    end
    chk("illegal", {63'd0, illegal}, {63'd0, ev_ill.exists(cyc) != 0});
    if (ev_op.exists(cyc)) begin
      chk("ibox_opcode", {51'd0, ibox_opcode}, {51'd0, ev_op[cyc]});
      chk("ibox_a", ibox_a, ev_a[cyc]);
      chk("ibox_b", ibox_b, ev_b[cyc]);
    end
    acc = v && cyc >= nrdy;
    if (acc) model_issue(w, legal);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] w, input bit legal);
    bit acc;
    acc = 0;
    for (int t = 0; t < 2 * L + 4 && !acc; t++) step(1, w, legal, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) step(0, 32'd0, 0, acc);
  endtask

  task automatic do_reset();
    rst = 1;
    inst_valid = 0;
    #1;
    chk("rst inst_ready", {63'd0, inst_ready}, 64'd0);
    chk("rst wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst wb_reg", {59'd0, wb_reg}, 64'd0);
    chk("rst wb_data", wb_data, 64'd0);
    chk("rst illegal", {63'd0, illegal}, 64'd0);
    chk("rst ibox_opcode", {51'd0, ibox_opcode}, 64'd0);
    chk("rst ibox_a", ibox_a, 64'd0);
    chk("rst ibox_b", ibox_b, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    ev_wb.delete();
    ev_ill.delete();
    ev_reg.delete();
    ev_data.delete();
    ev_op.delete();
    ev_a.delete();
    ev_b.delete();
    cyc += 10;
    nrdy = cyc;
  endtask

  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 8);
    return r == 8 ? 5'd31 : 5'(r);
  endfunction

  initial begin
    bit acc;
    logic [12:0] g;
    @(posedge clk);
    #1;
    do_reset();
    issue(32'h203FFFFF, 1);
    issue(mem(6'h09, 5'd2, 5'd31, 16'd1), 1);
    issue(opl({6'h10, 7'h20}, 5'd2, 8'd5, 5'd3), 1);
    issue(opr({6'h11, 7'h24}, 5'd4, 5'd1, 5'd5), 1);
    issue(mem(6'h08, 5'd4, 5'd31, 16'd1), 1);
    issue(opr({6'h11, 7'h24}, 5'd4, 5'd2, 5'd5), 1);
    issue(opr({6'h11, 7'h20}, 5'd5, 5'd31, 5'd7), 1);
    issue(opr({6'h13, 7'h20}, 5'd3, 5'd3, 5'd6), 1);
    issue(opr({6'h10, 7'h20}, 5'd6, 5'd31, 5'd8), 1);
    issue(mem(6'h29, 5'd1, 5'd2, 16'h0010), 0);
    issue(opr({6'h11, 7'h61}, 5'd31, 5'd1, 5'd9), 0);
    issue(opr({6'h10, 7'h20}, 5'd1, 5'd1, 5'd31), 1);
    issue(opr({6'h10, 7'h20}, 5'd31, 5'd31, 5'd9), 1);
    idle(3);
    issue(opr({6'h13, 7'h20}, 5'd3, 5'd3, 5'd6), 1);
    idle(1);
    do_reset();
    idle(L + 3);
    issue(opr({6'h10, 7'h20}, 5'd1, 5'd31, 5'd7), 1);
    idle(3);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 15) idle(1);
      else case ($urandom_range(0, 9))
        0: issue(mem($urandom_range(0, 1) != 0 ? 6'h09 : 6'h08, rreg(), rreg(), 16'($urandom)), 1);
        1: begin
          g = BAD[$urandom_range(0, 6)];
          issue(opr(g, rreg(), rreg(), rreg()), 0);
        end
        default: begin
          g = GOOD[$urandom_range(0, 15)];
          if ($urandom_range(0, 1) != 0) issue(opl(g, rreg(), 8'($urandom), rreg()), 1);
          else issue(opr(g, rreg(), rreg(), rreg()), 1);
        end
      endcase
    end
    idle(L + 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
